// File: rtl/edge_event_arbiter.sv
// Edge detector feeding a round-robin event queue: edge -> ev_valid in 2 clk edges, one event/cycle with valid/ready hold.
// Define EDGE_OVF_CNT_EN to add an 8-bit saturating ovf_cnt output.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CW-1:0]   ev_ch,
    output logic            ev_rise,
    output logic [N_CH-1:0] pending,
    output logic            overflow,
    input  logic            ovf_clr
`ifdef EDGE_OVF_CNT_EN
    ,
    output logic [7:0]      ovf_cnt
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [N_CH-1:0] last_in_q;
    logic            primed_q;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] pol_q, pol_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic            rise_q, rise_d;
    logic [CW-1:0]   last_grant_q, last_grant_d;
    logic            ovf_q, ovf_d;

    logic [N_CH-1:0] edge_det;
    logic [N_CH-1:0] pend_clr;
    logic            gnt_found;
    logic [CW-1:0]   gnt_ch;
    logic [CW-1:0]   idx_v;
    logic            take;
    logic            ovf_hit;

    // The priming cycle after reset suppresses edges against the cleared last_in.
    assign edge_det = primed_q ? (in ^ last_in_q) : '0;

    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx_v     = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx_v = CW'((int'(last_grant_q) + k) % N_CH);
            if (!gnt_found && pend_q[idx_v]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx_v;
            end
        end
    end

    assign take     = gnt_found && ((state_q == ST_IDLE) || ev_ready);
    assign pend_clr = take ? (N_CH'(1) << gnt_ch) : '0;
    // An edge on the channel granted this cycle re-queues it cleanly; anything else queued is lost.
    assign ovf_hit  = |(edge_det & pend_q & ~pend_clr);
    assign pend_d   = (pend_q & ~pend_clr) | edge_det;
    assign pol_d    = (pol_q & ~edge_det) | (in & edge_det);
    assign ovf_d    = ovf_hit | (ovf_q & ~ovf_clr);

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        rise_d       = rise_q;
        last_grant_d = last_grant_q;
        if (take) begin
            state_d      = ST_PRESENT;
            ch_d         = gnt_ch;
            rise_d       = pol_q[gnt_ch];
            last_grant_d = gnt_ch;
        end else if ((state_q == ST_PRESENT) && ev_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_in_q    <= '0;
            primed_q     <= 1'b0;
            pend_q       <= '0;
            pol_q        <= '0;
            ch_q         <= '0;
            rise_q       <= 1'b0;
            last_grant_q <= CW'(N_CH - 1);
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_in_q    <= in;
            primed_q     <= 1'b1;
            pend_q       <= pend_d;
            pol_q        <= pol_d;
            ch_q         <= ch_d;
            rise_q       <= rise_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef EDGE_OVF_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ovf_hit) begin
            if (ovf_clr) begin
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_cnt = cnt_q;
`endif

    assign ev_valid = (state_q == ST_PRESENT);
    assign ev_ch    = ch_q;
    assign ev_rise  = rise_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expectations.
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] in_s;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_ch;
    logic       ev_rise;
    logic [3:0] pending;
    logic       overflow;
    logic       ovf_clr;
`ifdef EDGE_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    edge_event_arbiter #(.N_CH(4), .CW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ch    (ev_ch),
        .ev_rise  (ev_rise),
        .pending  (pending),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef EDGE_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut(input logic [3:0] v);
        reset   = 1'b0;
        in_s    = v;
        ovf_clr = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        in_s     = 4'b1111;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        check("rst_valid", 32'(ev_valid), 32'h0);
        check("rst_ch", 32'(ev_ch), 32'h0);
        check("rst_rise", 32'(ev_rise), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);

        // Release with all inputs high: nothing may be reported.
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("prime_valid", 32'(ev_valid), 32'h0);
            check("prime_pending", 32'(pending), 32'h0);
        end

        // One-cycle pulse on ch2.
        reset_dut(4'b0000);
        ev_ready = 1'b1;
        in_s = 4'b0100;
        tick();
        check("pulse_pend", 32'(pending), 32'h4);
        check("pulse_valid0", 32'(ev_valid), 32'h0);
        in_s = 4'b0000;
        tick();
        check("pulse_v1", 32'(ev_valid), 32'h1);
        check("pulse_ch1", 32'(ev_ch), 32'h2);
        check("pulse_rise1", 32'(ev_rise), 32'h1);
        check("pulse_pend1", 32'(pending), 32'h4);
        check("pulse_ovf", 32'(overflow), 32'h0);
        tick();
        check("pulse_v2", 32'(ev_valid), 32'h1);
        check("pulse_ch2", 32'(ev_ch), 32'h2);
        check("pulse_rise2", 32'(ev_rise), 32'h0);
        check("pulse_pend2", 32'(pending), 32'h0);
        tick();
        check("pulse_idle", 32'(ev_valid), 32'h0);

        // Simultaneous rises on ch0, ch1, ch3.
        reset_dut(4'b0000);
        ev_ready = 1'b1;
        in_s = 4'b1011;
        tick();
        check("multi_pend", 32'(pending), 32'hB);
        tick();
        check("multi_v0", 32'(ev_valid), 32'h1);
        check("multi_ch0", 32'(ev_ch), 32'h0);
        check("multi_rise0", 32'(ev_rise), 32'h1);
        tick();
        check("multi_ch1", 32'(ev_ch), 32'h1);
        tick();
        check("multi_ch3", 32'(ev_ch), 32'h3);
        check("multi_pend_end", 32'(pending), 32'h0);
        tick();
        check("multi_idle", 32'(ev_valid), 32'h0);

        // Stalled consumer with ch1 presented, ch1 toggles twice.
        reset_dut(4'b0000);
        ev_ready = 1'b0;
        in_s = 4'b0010;
        tick();
        tick();
        check("stall_v", 32'(ev_valid), 32'h1);
        check("stall_ch", 32'(ev_ch), 32'h1);
        in_s = 4'b0000;
        tick();
        check("stall_ovf_a", 32'(overflow), 32'h0);
        in_s = 4'b0010;
        tick();
        check("stall_ovf", 32'(overflow), 32'h1);
        check("stall_pend", 32'(pending), 32'h2);
        check("stall_v_hold", 32'(ev_valid), 32'h1);
        check("stall_ch_hold", 32'(ev_ch), 32'h1);
        check("stall_rise_hold", 32'(ev_rise), 32'h1);
`ifdef EDGE_OVF_CNT_EN
        check("stall_cnt", 32'(ovf_cnt), 32'h1);
`endif
        ovf_clr = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 32'h0);
`ifdef EDGE_OVF_CNT_EN
        check("clr_cnt", 32'(ovf_cnt), 32'h0);
`endif
        in_s = 4'b0000;
        tick();
        check("clr_vs_ovf", 32'(overflow), 32'h1);
`ifdef EDGE_OVF_CNT_EN
        check("clr_vs_cnt", 32'(ovf_cnt), 32'h1);
`endif
        ovf_clr  = 1'b0;
        ev_ready = 1'b1;
        tick();
        check("drain_ch", 32'(ev_ch), 32'h1);
        check("drain_rise", 32'(ev_rise), 32'h0);
        check("drain_pend", 32'(pending), 32'h0);
        tick();
        check("drain_idle", 32'(ev_valid), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Continuous toggling on every channel.
        reset_dut(4'b0000);
        check("rr_ovf_rst", 32'(overflow), 32'h0);
        ev_ready = 1'b1;
        in_s = 4'b1111;
        tick();
        check("rr_pend", 32'(pending), 32'hF);
        for (int n = 2; n < 10; n++) begin
            in_s = ~in_s;
            tick();
            check("rr_valid", 32'(ev_valid), 32'h1);
            check("rr_ch", 32'(ev_ch), 32'((n - 2) % 4));
            check("rr_rise", 32'(ev_rise), 32'(n % 2 == 0));
        end

        // Asynchronous reset mid-handshake.
        reset_dut(4'b0000);
        ev_ready = 1'b0;
        in_s = 4'b0011;
        tick();
        tick();
        check("ar_valid_pre", 32'(ev_valid), 32'h1);
        check("ar_pend_pre", 32'(pending), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(ev_valid), 32'h0);
        check("ar_pend", 32'(pending), 32'h0);
        check("ar_ch", 32'(ev_ch), 32'h0);
        reset = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
